zeta_addr_gen: RTL



---
 rtl/ntt_pkg.sv | 22 ++
 rtl/zeta_lane_addr.sv | 48 ++++
 rtl/zeta_addr_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constant helpers for the NTT zeta address path.
package ntt_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} zeta_fsm_e;

  localparam int ZETA_ADDR_WIDTH = 7;
  typedef logic [ZETA_ADDR_WIDTH-1:0] zeta_addr_t;

  // Width helper that never returns zero, so one-value counters still get a bit.
  function automatic int clog2w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int beats_of(input int n, input int nbu);
    return n / (2 * nbu);
  endfunction

  function automatic int stages_of(input int n);
    return $clog2(n) - 1;
  endfunction

endpackage

// File: rtl/zeta_lane_addr.sv
// One lane's zeta address: base + j/len with base = N/(2*len), all as shifts.
// Optional macro ZETA_INV_MIRROR_EN mirrors INTT addresses within each stage group.
module zeta_lane_addr
  import ntt_pkg::*;
#(
  parameter int N          = 256,
  parameter int NUM_BU     = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int LANE       = 0,
  localparam int L2W       = clog2w($clog2(N)),
  localparam int BW        = clog2w(beats_of(N, NUM_BU))
) (
  input  logic [L2W-1:0]        len_log2,
  input  logic [BW-1:0]         beat,
  input  logic                  is_ntt,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int LOG2N = $clog2(N);
  localparam int BEATS = beats_of(N, NUM_BU);
  localparam int W     = ADDR_WIDTH + 2;

  logic [L2W-1:0] sh;
  logic [W-1:0]   j;
  logic [W-1:0]   base;
  logic [W-1:0]   raw;

  always_comb begin
    sh   = L2W'(LOG2N - 1) - len_log2;
    j    = W'(LANE * BEATS) + W'(beat);
    base = W'(1) << sh;
    raw  = base + (j >> len_log2);
  end

`ifdef ZETA_INV_MIRROR_EN
  // 3*base-1-raw walks the group [base, 2*base) from the top down.
  logic [W-1:0] mir;
  logic [1:0]   unused_hi;
  always_comb mir = (base << 1) + base - W'(1) - raw;
  assign addr      = is_ntt ? raw[ADDR_WIDTH-1:0] : mir[ADDR_WIDTH-1:0];
  assign unused_hi = is_ntt ? raw[W-1:ADDR_WIDTH] : mir[W-1:ADDR_WIDTH];
`else
  logic [2:0] unused_bits;
  assign addr        = raw[ADDR_WIDTH-1:0];
  assign unused_bits = {is_ntt, raw[W-1:ADDR_WIDTH]};
`endif

endmodule

// File: rtl/zeta_addr_gen.sv
// Walks every stage/beat of an NTT or INTT, emitting NUM_BU zeta addresses per beat (macro ZETA_INV_MIRROR_EN).
// Latency: first beat valid 1 cycle after start; one beat per cycle when zeta_ready stays high.
// Backpressure: outputs hold while zeta_valid & !zeta_ready; next beat is precomputed so there are no bubbles.
module zeta_addr_gen
  import ntt_pkg::*;
#(
  parameter int N          = 256,
  parameter int NUM_BU     = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int LEN_WIDTH  = 8,
  localparam int BW        = clog2w(beats_of(N, NUM_BU))
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         is_ntt,
  input  logic                         zeta_ready,
  output logic                         zeta_valid,
  output logic [NUM_BU*ADDR_WIDTH-1:0] addr_zeta,
  output logic [LEN_WIDTH-1:0]         len_o,
  output logic [BW-1:0]                beat_o,
  output logic                         busy,
  output logic                         done
);

  localparam int LOG2N = $clog2(N);
  localparam int BEATS = beats_of(N, NUM_BU);
  localparam int L2W   = clog2w(LOG2N);

  localparam logic [L2W-1:0] LEN_LOG2_MAX = L2W'(LOG2N - 1);
  localparam logic [L2W-1:0] LEN_LOG2_MIN = L2W'(1);
  localparam logic [BW-1:0]  BEAT_LAST    = BW'(BEATS - 1);

  zeta_fsm_e state, state_n;
  logic      mode, mode_n;
  logic [L2W-1:0] len_log2, len_log2_n;
  logic [BW-1:0]  beat_n;
  logic      valid_n, busy_n, done_n, load;
  logic      hs, last_beat, last_stage;
  logic [NUM_BU*ADDR_WIDTH-1:0] addr_n;

  assign hs         = zeta_valid & zeta_ready;
  assign last_beat  = (beat_o == BEAT_LAST);
  assign last_stage = mode ? (len_log2 == LEN_LOG2_MIN) : (len_log2 == LEN_LOG2_MAX);

  always_comb begin
    state_n    = state;
    mode_n     = mode;
    len_log2_n = len_log2;
    beat_n     = beat_o;
    valid_n    = zeta_valid;
    busy_n     = busy;
    done_n     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = RUN;
          mode_n     = is_ntt;
          len_log2_n = is_ntt ? LEN_LOG2_MAX : LEN_LOG2_MIN;
          beat_n     = '0;
          valid_n    = 1'b1;
          busy_n     = 1'b1;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (hs) begin
          if (last_beat && last_stage) begin
            state_n = DONE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            load = 1'b1;
            if (last_beat) begin
              beat_n     = '0;
              len_log2_n = mode ? (len_log2 - L2W'(1)) : (len_log2 + L2W'(1));
            end else begin
              beat_n = beat_o + BW'(1);
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lanes see the next beat so the registered outputs update in the handshake cycle.
  for (genvar i = 0; i < NUM_BU; i++) begin : g_lane
    zeta_lane_addr #(
      .N          (N),
      .NUM_BU     (NUM_BU),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANE       (i)
    ) u_lane (
      .len_log2 (len_log2_n),
      .beat     (beat_n),
      .is_ntt   (mode_n),
      .addr     (addr_n[i*ADDR_WIDTH +: ADDR_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= 1'b0;
      len_log2   <= '0;
      beat_o     <= '0;
      zeta_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_zeta  <= '0;
      len_o      <= '0;
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      zeta_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
      if (load) begin
        len_log2  <= len_log2_n;
        beat_o    <= beat_n;
        addr_zeta <= addr_n;
        len_o     <= LEN_WIDTH'(1) << len_log2_n;
      end
    end
  end

endmodule
